// File: rtl/lsu_mem_master_pkg.sv
// Shared widths, RISC-V width codes, response error codes and FSM encoding
// for the load/store memory master.
package lsu_mem_master_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned MEM_WORDS_DEF = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_RANGE    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_STORE_RD = 3'd2,
    ST_STORE_WR = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// sub-word merge of store data into a memory word.
module lsu_lane_align
  import lsu_mem_master_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_word,
  input  logic [15:0]     i_wdata,
  output logic [XLEN-1:0] o_load_c,
  output logic [XLEN-1:0] o_merge_c
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = {i_addr_lo, 3'b000};
  assign w_half_sh = {i_addr_lo[1], 4'b0000};
  assign w_byte    = 8'(i_word >> w_byte_sh);
  assign w_half    = 16'(i_word >> w_half_sh);

  always_comb begin
    o_load_c = i_word;
    case (i_funct3)
      F3_B:    o_load_c = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load_c = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    o_load_c = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   o_load_c = {{(XLEN-16){1'b0}}, w_half};
      default: o_load_c = i_word;
    endcase
  end

  // Clear the target lane, then OR in the right-aligned store data.
  always_comb begin
    o_merge_c = i_word;
    case (i_funct3)
      F3_B: o_merge_c = (i_word & ~(XLEN'(8'hFF) << w_byte_sh))
                        | (XLEN'(i_wdata[7:0]) << w_byte_sh);
      F3_H: o_merge_c = (i_word & ~(XLEN'(16'hFFFF) << w_half_sh))
                        | (XLEN'(i_wdata) << w_half_sh);
      default: o_merge_c = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: latches one request, checks it, and drives word
// reads/writes (read-modify-write for sub-word stores) to main memory.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned IDX_W = XLEN - 2;

  state_t           r_state;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [15:0]      r_wdata;
  logic [XLEN-1:0]  r_rdata;
  logic [1:0]       r_err;

  logic             w_accept;
  logic             w_legal_st;
  logic             w_legal_ld;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_range;
  logic [IDX_W-1:0] w_idx;
  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_merge;

  assign w_accept   = req_valid & req_ready;
  assign w_idx      = req_addr[XLEN-1:2];
  assign w_legal_st = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
  assign w_legal_ld = w_legal_st || (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
  assign w_illegal  = req_we ? !w_legal_st : !w_legal_ld;
  assign w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                    || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign w_range    = (w_idx >= IDX_W'(MEM_WORDS));

  lsu_lane_align u_lane_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_word    (mem_rdata),
    .i_wdata   (r_wdata),
    .o_load_c  (w_load),
    .o_merge_c (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_funct3     <= F3_B;
      r_addr_lo    <= 2'b00;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= ERR_OK;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= ERR_OK;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            req_ready <= 1'b0;
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            r_rdata   <= '0;
            r_err     <= ERR_OK;
            mem_addr  <= XLEN'(w_idx);
            // Error priority: illegal width, then alignment, then range.
            if (w_illegal) begin
              r_err   <= ERR_ILLEGAL;
              r_state <= ST_RESP;
            end else if (w_misalign) begin
              r_err   <= ERR_MISALIGN;
              r_state <= ST_RESP;
            end else if (w_range) begin
              r_err   <= ERR_RANGE;
              r_state <= ST_RESP;
            end else if (!req_we) begin
              mem_read_en <= 1'b1;
              r_state     <= ST_LOAD;
            end else if (req_funct3 == F3_W) begin
              mem_write_en <= 1'b1;
              mem_wdata    <= req_wdata;
              r_state      <= ST_STORE_WR;
            end else begin
              mem_read_en <= 1'b1;
              r_state     <= ST_STORE_RD;
            end
          end
        end
        ST_LOAD: begin
          mem_read_en <= 1'b0;
          r_rdata     <= w_load;
          r_state     <= ST_RESP;
        end
        ST_STORE_RD: begin
          mem_read_en  <= 1'b0;
          mem_wdata    <= w_merge;
          mem_write_en <= 1'b1;
          r_state      <= ST_STORE_WR;
        end
        ST_STORE_WR: begin
          mem_write_en <= 1'b0;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= r_rdata;
          resp_err   <= r_err;
          req_ready  <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a byte-addressed reference memory
// predicts each response, a monitor checks responses and memory traffic.
module tb_lsu_mem_master;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] widx;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  logic [7:0]  ref_b [0:4095];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_data = 32'h0;

  exp_t        q[$];
  exp_t        m_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_edge = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          tot_wr = 0;
  int          tot_resp = 0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;

  lsu_mem_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) n_edge <= n_edge + 1;

  assign mem_rdata = mem_read_en ? mem[mem_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[9:0]] <= mem_wdata;
    else if (pl_en)   mem[pl_idx] <= pl_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  // Reference: RISC-V little-endian byte semantics over a byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int size;
    bit legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e = '{rdata: 32'h0, err: 2'b00, lat: 0, nrd: 0, nwr: 0, widx: addr >> 2, wdata: 32'h0, acc: 0};
    if (!legal) begin
      e.err = 2'b10; e.lat = 1;
    end else if ((addr % 32'(size)) != 0) begin
      e.err = 2'b01; e.lat = 1;
    end else if ((addr >> 2) >= 32'd1024) begin
      e.err = 2'b11; e.lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v |= 32'(ref_b[int'(addr) + i]) << (8 * i);
      if (!f3[2] && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8 * size);
      e.rdata = v; e.lat = 2; e.nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) ref_b[int'(addr) + i] = 8'(wd >> (8 * i));
      e.wdata = ref_word(int'(addr >> 2));
      e.lat = (size == 4) ? 2 : 3;
      e.nrd = (size == 4) ? 0 : 1;
      e.nwr = 1;
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 10'(idx); pl_data = w;
    for (int i = 0; i < 4; i++) ref_b[4*idx+i] = 8'(w >> (8 * i));
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit push);
    exp_t e;
    int   waitc;
    int   acc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc = n_edge;
    @(posedge clk);
    if (push) begin
      check("inflight", 32'(q.size()), 32'd0);
      model(we, f3, addr, wd, e);
      e.acc = acc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int w;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while ((q.size() != 0 || !req_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_mem_read_en"}, 32'(mem_read_en), 32'd0);
    check({tag, "_mem_write_en"}, 32'(mem_write_en), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // Monitor: memory traffic and responses, compared against the queue head.
  always @(negedge clk) begin
    if (mem_write_en) tot_wr++;
    if (resp_valid) tot_resp++;
    if (rst) begin
      rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (mem_read_en) begin
        rd_cnt++;
        if (q.size() > 0) check("rd_addr", mem_addr, q[0].widx);
      end
      if (mem_write_en) begin
        wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata;
      end
      if (resp_valid) begin
        if (q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
        else begin
          m_e = q.pop_front();
          check("rdata", resp_rdata, m_e.rdata);
          check("err", 32'(resp_err), 32'(m_e.err));
          check("latency", 32'(n_edge - m_e.acc - 1), 32'(m_e.lat));
          check("n_reads", 32'(rd_cnt), 32'(m_e.nrd));
          check("n_writes", 32'(wr_cnt), 32'(m_e.nwr));
          if (m_e.nwr != 0) begin
            check("wr_addr", wr_addr, m_e.widx);
            check("wr_data", wr_data, m_e.wdata);
          end
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          r;
    int          t_wr;
    int          t_resp;
    int          bad;

    @(negedge clk);
    check_reset_outputs("por");
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);
    @(negedge clk);
    rst = 1'b0;

    // Loads from a known word.
    set_word(4, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1);
    drain();

    // Sub-word stores.
    set_word(4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h11, 32'h000000AA, 1'b1);
    drain();
    check("sb_mem", mem[4], 32'h1122AA44);
    set_word(4, 32'h11223344);
    issue(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b1);
    drain();
    check("sh_mem", mem[4], 32'hBEEF3344);

    // Errors and the last in-range word.
    issue(1'b0, 3'b001, 32'h11, 32'h0, 1'b1);
    issue(1'b1, 3'b010, 32'h12, 32'h12345678, 1'b1);
    issue(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b1);
    issue(1'b0, 3'b010, 32'd4096, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'd4092, 32'h0, 1'b1);
    issue(1'b0, 3'b111, 32'h10, 32'h0, 1'b1);
    drain();

    // Reset while a byte store sits in its read phase.
    set_word(5, 32'h55667788);
    t_wr = tot_wr;
    t_resp = tot_resp;
    issue(1'b1, 3'b000, 32'h15, 32'h000000AB, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    check("rst_no_write", 32'(tot_wr - t_wr), 32'd0);
    check("rst_no_resp", 32'(tot_resp - t_resp), 32'd0);
    check("rst_mem", mem[5], 32'h55667788);
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        r  = we ? $urandom_range(0, 2) : $urandom_range(0, 4);
        f3 = (r <= 2) ? 3'(r) : 3'(r + 1);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      r = $urandom_range(0, 9);
      if (r < 6)      addr = 32'($urandom_range(0, 255));
      else if (r < 9) addr = 32'($urandom_range(0, 4095));
      else            addr = $urandom | 32'h0000_1000;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        else if (f3[1:0] != 2'b00) addr[1:0] = 2'b00;
      end
      wd = $urandom;
      issue(we, f3, addr, wd, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
      end
    end
    drain();

    // Back-to-back with req_valid held high.
    issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    drain();
    check("b2b_mem", mem[8], 32'hCAFEF00D);

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_word(i)) bad++;
    check("mem_final", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
